alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Requester-side controller for the shared 8-bit ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's operand, op and output-enable inputs. It waits the ALU's registered latency, then captures the ALU result bus and flags. It returns them over a valid/ready response channel and maintains the architectural flags register {C,N,O,Z} consumed by branch logic.

Parameters:
WIDTH, 8, data/operand width
ALU_LATENCY, 1, ALU clock edges between operands applied and result valid on bus (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
req_valid  input  1  request present
req_ready  output  1  sequencer can accept request
req_op  input  3  ALU op code (add 000, sub 001, or 010, and 011, not 100, comp 101, shr 110, shl 111)
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_data  output  WIDTH  captured ALU result
resp_flags  output  4  raw ALU flags captured with result {C,N,O,Z}
flags_q  output  4  architectural flags register {C,N,O,Z}
busy  output  1  high in any state other than IDLE
alu_a  output  WIDTH  to ALU in_A
alu_b  output  WIDTH  to ALU in_B
alu_op  output  3  to ALU op
alu_enable_out  output  1  to ALU in_enable_out; ALU bus is Z when low
alu_out  input  WIDTH  ALU result bus (tristate, shared)
alu_flags  input  4  ALU flags {C[3],N[2],O[1],Z[0]}

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - All outputs 0: req_ready=0 during reset, resp_valid=0, resp_data=0, resp_flags=0, flags_q=0, alu_a/alu_b/alu_op=0, alu_enable_out=0, busy=0.
  - Reset mid-operation aborts with no response.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready=1. On req_valid&&req_ready, latch req_a/b/op into alu_a/b/op, load counter=ALU_LATENCY-1, go to ISSUE.
- ISSUE:
  - alu_a/b/op held stable, alu_enable_out=1.
  - Counter decrements each edge. At the edge with counter==0, go to CAPTURE.
- CAPTURE:
  - alu_enable_out=1.
  - At the edge, latch resp_data<=alu_out and resp_flags<=alu_flags.
  - If latched op is add or sub, also flags_q<=alu_flags. All other ops leave flags_q unchanged.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_data/resp_flags stable; alu_enable_out=0.
  - On resp_ready go to IDLE. resp_valid holds indefinitely under backpressure.
- Latency:
  - Accept edge E; resp_valid first high after edge E+ALU_LATENCY+1.
  - Minimum request period ALU_LATENCY+3 cycles.
  - No request is accepted while busy; req_ready=0 outside IDLE.
- alu_enable_out is low in IDLE and RESP so the shared bus is released.
- Operand/op outputs hold their last values outside ISSUE/CAPTURE.
- Unknown op codes do not exist (3-bit, all defined).
- No arithmetic is performed in this block.

Decomposition:
- Shared package alu_pkg:
  - op code localparams (ADD..SHL)
  - flag bit indices (FLAG_C=3, FLAG_N=2, FLAG_O=1, FLAG_Z=0)
  - FSM state encoding
- Sub-module: alu_latency_counter, a loadable down-counter with a zero flag, reusable by other ALU clients.

Test Plan:
- Add 0x40+0x41, resp_ready=1:
  - resp_data=0x81, resp_flags=4'b0110.
  - flags_q=4'b0110; resp_valid at E+2.
- Sub 0x01-0x02:
  - resp_data=0xFF, resp_flags=4'b1100, flags_q=4'b1100.
- After the sub, or 0x03|0x11:
  - resp_data=0x13.
  - flags_q remains 4'b1100 (logical ops do not update flags).
- Backpressure: add 0x03+0x11 with resp_ready=0 for 5 cycles:
  - resp_valid stays 1, resp_data=0x14 stable.
  - req_ready=0, alu_enable_out=0; completes on resp_ready=1.
- rst_n pulsed low during ISSUE:
  - Immediately resp_valid=0, alu_enable_out=0, flags_q=0, state IDLE.
  - req_ready=1 after release; no response emitted.
- ALU_LATENCY=3, comp 0x53,0x53:
  - alu_enable_out high 4 cycles, resp_data=0x01, resp_valid at E+4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for clients of the 8-bit ALU: op codes, flag bit
// positions and the requester FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_COMP = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } seq_state_t;

    // Only arithmetic ops feed the architectural flags seen by branch logic.
    function automatic logic op_updates_flags(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_latency_counter.sv
// Loadable down-counter with a zero flag; counts the ALU's registered
// latency for any requester that has to wait on the shared result bus.
module alu_latency_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/alu_sequencer.sv
// Requester-side controller for the shared ALU: issues one operation,
// waits out the ALU latency, captures result/flags and returns them.
module alu_sequencer #(
    parameter int WIDTH       = 8,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [3:0]       resp_flags,
    output logic [3:0]       flags_q,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_enable_out,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_flags
);
    import alu_pkg::*;

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    seq_state_t       state_r, state_nxt_s;
    logic             req_ready_r, resp_valid_r, busy_r, alu_en_r;
    logic             req_ready_s, resp_valid_s, busy_s, alu_en_s;
    logic [WIDTH-1:0] alu_a_r, alu_b_r, resp_data_r;
    logic [2:0]       alu_op_r;
    logic [3:0]       resp_flags_r, flags_q_r;
    logic             accept_s, cnt_zero_s;

    // req_ready is registered, so it is low for the first cycle after reset.
    assign accept_s = req_valid && req_ready_r;

    alu_latency_counter #(.CNT_W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept_s),
        .load_val (CNT_W'(ALU_LATENCY - 1)),
        .dec      (state_r == ST_ISSUE),
        .zero     (cnt_zero_s)
    );

    // State register plus registered handshake/bus-control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            alu_en_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            req_ready_r  <= req_ready_s;
            resp_valid_r <= resp_valid_s;
            busy_r       <= busy_s;
            alu_en_r     <= alu_en_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:    if (accept_s)   state_nxt_s = ST_ISSUE;   else state_nxt_s = ST_IDLE;
            ST_ISSUE:   if (cnt_zero_s) state_nxt_s = ST_CAPTURE; else state_nxt_s = ST_ISSUE;
            ST_CAPTURE: state_nxt_s = ST_RESP;
            ST_RESP:    if (resp_ready) state_nxt_s = ST_IDLE;    else state_nxt_s = ST_RESP;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies track the state.
    always_comb begin
        req_ready_s  = 1'b0;
        resp_valid_s = 1'b0;
        busy_s       = 1'b1;
        alu_en_s     = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                busy_s      = 1'b0;
            end
            ST_ISSUE:   alu_en_s = 1'b1;
            ST_CAPTURE: alu_en_s = 1'b1;
            ST_RESP:    resp_valid_s = 1'b1;
            default: begin
                req_ready_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Operand latch on accept; result/flag capture one edge after the bus is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r      <= {WIDTH{1'b0}};
            alu_b_r      <= {WIDTH{1'b0}};
            alu_op_r     <= 3'b000;
            resp_data_r  <= {WIDTH{1'b0}};
            resp_flags_r <= 4'b0000;
            flags_q_r    <= 4'b0000;
        end else if (accept_s) begin
            alu_a_r  <= req_a;
            alu_b_r  <= req_b;
            alu_op_r <= req_op;
        end else if (state_r == ST_CAPTURE) begin
            resp_data_r  <= alu_out;
            resp_flags_r <= alu_flags;
            if (op_updates_flags(alu_op_r)) begin
                flags_q_r <= alu_flags;
            end else begin
                flags_q_r <= flags_q_r;
            end
        end else begin
            alu_a_r <= alu_a_r;
        end
    end

    assign req_ready      = req_ready_r;
    assign resp_valid     = resp_valid_r;
    assign busy           = busy_r;
    assign alu_enable_out = alu_en_r;
    assign alu_a          = alu_a_r;
    assign alu_b          = alu_b_r;
    assign alu_op         = alu_op_r;
    assign resp_data      = resp_data_r;
    assign resp_flags     = resp_flags_r;
    assign flags_q        = flags_q_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: two sequencers (latency 1 and 3) each driving a
// behavioural pipelined ALU stub; table vectors, random traffic, corner cases.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Latency-1 instance signals
    logic       req_valid1, req_ready1, resp_valid1, resp_ready1, busy1, alu_en1;
    logic [2:0] req_op1, alu_op1;
    logic [7:0] req_a1, req_b1, resp_data1, alu_a1, alu_b1, alu_out1;
    logic [3:0] resp_flags1, flags_q1, alu_flags1;
    // Latency-3 instance signals
    logic       req_valid3, req_ready3, resp_valid3, resp_ready3, busy3, alu_en3;
    logic [2:0] req_op3, alu_op3;
    logic [7:0] req_a3, req_b3, resp_data3, alu_a3, alu_b3, alu_out3;
    logic [3:0] resp_flags3, flags_q3, alu_flags3;

    alu_sequencer #(.WIDTH(8), .ALU_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_op(req_op1), .req_a(req_a1), .req_b(req_b1), .resp_valid(resp_valid1),
        .resp_ready(resp_ready1), .resp_data(resp_data1), .resp_flags(resp_flags1),
        .flags_q(flags_q1), .busy(busy1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
        .alu_enable_out(alu_en1), .alu_out(alu_out1), .alu_flags(alu_flags1));

    alu_sequencer #(.WIDTH(8), .ALU_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op3), .req_a(req_a3), .req_b(req_b3), .resp_valid(resp_valid3),
        .resp_ready(resp_ready3), .resp_data(resp_data3), .resp_flags(resp_flags3),
        .flags_q(flags_q3), .busy(busy3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
        .alu_enable_out(alu_en3), .alu_out(alu_out3), .alu_flags(alu_flags3));

    // Behavioural ALU: returns {C,N,O,Z, result}
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic c, o;
        c = 1'b0; o = 1'b0; w = 9'd0;
        case (op)
            OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                          o = (a[7] == b[7]) && (r[7] != a[7]); end
            OP_SUB: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                          o = (a[7] != b[7]) && (r[7] != a[7]); end
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_NOT:  r = ~a;
            OP_COMP: r = (a == b) ? 8'h01 : 8'h00;
            OP_SHR:  begin r = a >> 1; c = a[0]; end
            default: begin r = a << 1; c = a[7]; end
        endcase
        return {c, r[7], o, (r == 8'h00), r};
    endfunction

    // ALU stubs: registered pipelines of depth 1 and 3, bus released when not enabled.
    logic [11:0] pipe1;
    logic [11:0] pipe3 [3];
    always_ff @(posedge clk) begin
        pipe1    <= alu_ref(alu_op1, alu_a1, alu_b1);
        pipe3[0] <= alu_ref(alu_op3, alu_a3, alu_b3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign alu_out1   = alu_en1 ? pipe1[7:0]     : 8'h00;
    assign alu_flags1 = alu_en1 ? pipe1[11:8]    : 4'h0;
    assign alu_out3   = alu_en3 ? pipe3[2][7:0]  : 8'h00;
    assign alu_flags3 = alu_en3 ? pipe3[2][11:8] : 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One full transaction on the latency-1 instance with `stall` cycles of backpressure.
    task automatic run_txn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int stall, output logic [7:0] d, output logic [3:0] f,
                           output logic [3:0] fq, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready1 && guard < 20) begin @(negedge clk); guard++; end
        check("req_ready_idle", req_ready1, 1);
        req_valid1 = 1'b1; req_op1 = op; req_a1 = a; req_b1 = b; resp_ready1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid1 = 1'b0; req_a1 = 8'($urandom); req_b1 = 8'($urandom); req_op1 = 3'($urandom);
        lat = 0;
        while (!resp_valid1 && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
        d = resp_data1; f = resp_flags1;
        check("resp_bus_released", {req_ready1, alu_en1}, 0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); @(negedge clk);
            check("stall_hold", {resp_valid1, req_ready1, alu_en1, busy1}, 4'b1001);
            check("stall_data", {resp_flags1, resp_data1}, {f, d});
        end
        resp_ready1 = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready1 = 1'b0;
        check("resp_done", {resp_valid1, busy1}, 0);
        fq = flags_q1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b;
        int         stall;
        logic [7:0] d;
        logic [3:0] f, fq;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] d;
    logic [3:0] f, fq, model_fq;
    logic [11:0] ref_v;
    int         lat, en_cnt;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{OP_ADD, 8'h40, 8'h41, 0, 8'h81, 4'b0110, 4'b0110};
        vecs[1] = '{OP_SUB, 8'h01, 8'h02, 0, 8'hFF, 4'b1100, 4'b1100};
        vecs[2] = '{OP_OR,  8'h03, 8'h11, 0, 8'h13, 4'b0000, 4'b1100};
        vecs[3] = '{OP_ADD, 8'h03, 8'h11, 5, 8'h14, 4'b0000, 4'b0000};
        vecs[4] = '{OP_AND, 8'hF0, 8'h0F, 1, 8'h00, 4'b0001, 4'b0000};
        vecs[5] = '{OP_SHL, 8'h81, 8'h00, 0, 8'h02, 4'b1000, 4'b0000};

        rst_n = 1'b0;
        req_valid1 = 1'b0; resp_ready1 = 1'b0; req_op1 = 3'd0; req_a1 = 8'd0; req_b1 = 8'd0;
        req_valid3 = 1'b0; resp_ready3 = 1'b0; req_op3 = 3'd0; req_a3 = 8'd0; req_b3 = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {req_ready1, resp_valid1, alu_en1, busy1}, 0);
        check("reset_data", {resp_data1, resp_flags1, flags_q1}, 0);
        check("reset_alu_if", {alu_a1, alu_b1, alu_op1}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready1, 1);
        model_fq = 4'b0000;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall, d, f, fq, lat);
            check($sformatf("vec%0d_data", i), d, vecs[i].d);
            check($sformatf("vec%0d_flags", i), f, vecs[i].f);
            check($sformatf("vec%0d_flags_q", i), fq, vecs[i].fq);
            check($sformatf("vec%0d_latency", i), lat, 2);
            model_fq = vecs[i].fq;
        end

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom); ra = 8'($urandom); rb = 8'($urandom);
            if ((i % 5) == 0) rb = ra;
            ref_v = alu_ref(rop, ra, rb);
            if (rop == OP_ADD || rop == OP_SUB) model_fq = ref_v[11:8];
            run_txn(rop, ra, rb, int'($urandom_range(0, 3)), d, f, fq, lat);
            check("rand_data", d, ref_v[7:0]);
            check("rand_flags", f, ref_v[11:8]);
            check("rand_flags_q", fq, model_fq);
            check("rand_latency", lat, 2);
        end

        // Reset while the latency-1 sequencer is in ISSUE.
        run_txn(OP_ADD, 8'h40, 8'h41, 0, d, f, fq, lat);
        check("pre_reset_flags_q", fq, 4'b0110);
        @(negedge clk);
        req_valid1 = 1'b1; req_op1 = OP_SUB; req_a1 = 8'h01; req_b1 = 8'h02;
        @(posedge clk);
        @(negedge clk);
        req_valid1 = 1'b0;
        check("issue_enable", {busy1, alu_en1}, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {resp_valid1, alu_en1, flags_q1, busy1, req_ready1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", req_ready1, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_resp_after_abort", {resp_valid1, busy1}, 0);
        end

        // Latency-3 instance: enable window and response timing.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("l3_ready", req_ready3, 1);
            req_valid3 = 1'b1;
            req_op3 = (k == 0) ? OP_COMP : OP_SUB;
            req_a3  = 8'h53;
            req_b3  = (k == 0) ? 8'h53 : 8'h54;
            @(posedge clk);
            @(negedge clk);
            req_valid3 = 1'b0; req_a3 = 8'h00; req_b3 = 8'h00;
            en_cnt = alu_en3 ? 1 : 0;
            lat = 0;
            while (!resp_valid3 && lat < 20) begin
                @(posedge clk); lat++; @(negedge clk);
                if (alu_en3) en_cnt++;
            end
            check("l3_latency", lat, 4);
            check("l3_enable_cycles", en_cnt, 4);
            check("l3_data", resp_data3, (k == 0) ? 8'h01 : 8'hFF);
            check("l3_flags", resp_flags3, (k == 0) ? 4'b0000 : 4'b1100);
            check("l3_flags_q", flags_q3, (k == 0) ? 4'b0000 : 4'b1100);
            resp_ready3 = 1'b1;
            @(posedge clk); @(negedge clk);
            resp_ready3 = 1'b0;
            check("l3_done", resp_valid3, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
